// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: port identifiers and the idle/fetch funct3 code.
package mem_arbiter_pkg;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_AUX = 1'b1
    } arb_port_t;

    localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/mem_arbiter_arb_grant.sv
// Combinational grant decision for the two-port memory arbiter.
// `MEM_ARB_FIXED_PRIO_EN selects fixed port-0 priority instead of round-robin with burst limit.
module arb_grant
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic             req0,
    input  logic             req1,
    input  arb_port_t        last_owner,
    input  logic [CNT_W-1:0] burst_cnt,
    output logic             gnt0,
    output logic             gnt1
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_state;
    assign unused_state = ^{burst_cnt, last_owner};

    always_comb begin
        gnt0 = req0;
        gnt1 = req1 & ~req0;
    end
`else
    logic      keep_burst;
    arb_port_t winner;

    // A zero count means the last owner was not granted in the previous cycle,
    // so it has no burst to continue (this is what lets port 0 win the first tie).
    assign keep_burst = (burst_cnt != '0) && (burst_cnt < CNT_W'(MAX_BURST));

    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        winner = PORT_CPU;
        if (req0 && !req1) begin
            gnt0 = 1'b1;
        end else if (req1 && !req0) begin
            gnt1 = 1'b1;
        end else if (req0 && req1) begin
            winner = keep_burst ? last_owner : arb_port_t'(~last_owner);
            gnt0   = (winner == PORT_CPU);
            gnt1   = (winner == PORT_AUX);
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one synchronous-read memory port between the CPU core and the loader.
// `MEM_ARB_FIXED_PRIO_EN selects fixed port-0 priority instead of round-robin with burst limit.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wd0,
    input  logic [31:0] wd1,
    input  logic [2:0]  funct3_0,
    input  logic [2:0]  funct3_1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rd0,
    output logic [31:0] rd1,
    output logic        mem_wen,
    output logic [31:0] mem_ra,
    output logic [31:0] mem_wa,
    output logic [31:0] mem_wd,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_rd
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_port_t        last_owner_q, last_owner_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [1:0]       rvalid_q, rvalid_d;
    logic             gnt0_raw, gnt1_raw;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt >= CNT_W'(MAX_BURST)) ? CNT_W'(MAX_BURST) : cnt + CNT_W'(1);
    endfunction

    arb_grant #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_grant (
        .req0       (req0),
        .req1       (req1),
        .last_owner (last_owner_q),
        .burst_cnt  (burst_cnt_q),
        .gnt0       (gnt0_raw),
        .gnt1       (gnt1_raw)
    );

    // Grants are gated by reset so nothing reaches memory while rst_n is low.
    assign gnt0 = gnt0_raw & rst_n;
    assign gnt1 = gnt1_raw & rst_n;

    always_comb begin
        mem_wen    = 1'b0;
        mem_ra     = '0;
        mem_wa     = '0;
        mem_wd     = '0;
        mem_funct3 = FUNCT3_WORD;
        if (gnt0) begin
            mem_wen    = we0;
            mem_ra     = addr0;
            mem_wa     = addr0;
            mem_wd     = wd0;
            mem_funct3 = funct3_0;
        end else if (gnt1) begin
            mem_wen    = we1;
            mem_ra     = addr1;
            mem_wa     = addr1;
            mem_wd     = wd1;
            mem_funct3 = funct3_1;
        end
    end

    always_comb begin
        last_owner_d = last_owner_q;
        burst_cnt_d  = '0;
        if (gnt0 || gnt1) begin
            last_owner_d = gnt1 ? PORT_AUX : PORT_CPU;
            burst_cnt_d  = (last_owner_d != last_owner_q) ? CNT_W'(1) : sat_inc(burst_cnt_q);
        end
        rvalid_d = {gnt1 & ~we1, gnt0 & ~we0};
    end

    // Request stage -> read-return stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= PORT_AUX;
            burst_cnt_q  <= '0;
            rvalid_q     <= '0;
        end else begin
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            rvalid_q     <= rvalid_d;
        end
    end

    assign rvalid0 = rvalid_q[0];
    assign rvalid1 = rvalid_q[1];
    assign rd0     = rvalid_q[0] ? mem_rd : '0;
    assign rd1     = rvalid_q[1] ? mem_rd : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: the driver queues expected grants and read returns,
// a negedge monitor pops and compares them whenever the DUT grants or returns data.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wd0 = '0, wd1 = '0;
    logic [2:0]  funct3_0 = 3'b010, funct3_1 = 3'b010;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_wen;
    logic [31:0] rd0, rd1, mem_ra, mem_wa, mem_wd;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rd = '0;

    mem_arbiter #(.MAX_BURST(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0),
        .req1       (req1),
        .we0        (we0),
        .we1        (we1),
        .addr0      (addr0),
        .addr1      (addr1),
        .wd0        (wd0),
        .wd1        (wd1),
        .funct3_0   (funct3_0),
        .funct3_1   (funct3_1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .rvalid0    (rvalid0),
        .rvalid1    (rvalid1),
        .rd0        (rd0),
        .rd1        (rd1),
        .mem_wen    (mem_wen),
        .mem_ra     (mem_ra),
        .mem_wa     (mem_wa),
        .mem_wd     (mem_wd),
        .mem_funct3 (mem_funct3),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
    endfunction

    always @(posedge clk) mem_rd <= memval(mem_ra);

    typedef struct {
        logic        port;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        wen;
        logic [2:0]  f3;
    } gexp_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        req0 = 1'b0;
        req1 = 1'b0;
        we0  = 1'b0;
        we1  = 1'b0;
    endtask

    task automatic expect_grant(input logic p, input logic [31:0] a, input logic [31:0] d,
                                input logic w, input logic [2:0] f, input logic push_read);
        gq.push_back('{p, a, d, w, f});
        if (!w && push_read) rq.push_back('{p, memval(a)});
    endtask

    // Monitor
    initial begin
        gexp_t e;
        rexp_t r;
        forever begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                if (gq.size() == 0) begin
                    check("unexpected_grant", {30'b0, gnt1, gnt0}, 32'h0);
                end else begin
                    e = gq.pop_front();
                    check("gnt_port", {30'b0, gnt1, gnt0}, e.port ? 32'h2 : 32'h1);
                    check("mem_ra", mem_ra, e.addr);
                    check("mem_wa", mem_wa, e.addr);
                    check("mem_wd", mem_wd, e.wd);
                    check("mem_wen_f3", {28'b0, mem_funct3, mem_wen}, {28'b0, e.f3, e.wen});
                end
            end else begin
                check("idle_ra", mem_ra, 32'h0);
                check("idle_wa", mem_wa, 32'h0);
                check("idle_wd", mem_wd, 32'h0);
                check("idle_wen_f3", {28'b0, mem_funct3, mem_wen}, {28'b0, 3'b010, 1'b0});
            end
            if (rvalid0 || rvalid1) begin
                if (rq.size() == 0) begin
                    check("unexpected_rvalid", {30'b0, rvalid1, rvalid0}, 32'h0);
                end else begin
                    r = rq.pop_front();
                    check("rvalid_port", {30'b0, rvalid1, rvalid0}, r.port ? 32'h2 : 32'h1);
                    check("rd_data", r.port ? rd1 : rd0, r.data);
                    check("rd_other_zero", r.port ? rd0 : rd1, 32'h0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic tie_seq [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic tail_seq [2] = '{0, 0};
`else
    logic tie_seq [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    logic tail_seq [2] = '{1, 1};
`endif

    initial begin
        req0 = 1'b1;
        req1 = 1'b1;
        addr0 = 32'h100;
        addr1 = 32'h300;
        funct3_0 = 3'b010;
        funct3_1 = 3'b100;
        #1;
        check("rst_gnt", {30'b0, gnt1, gnt0}, 32'h0);
        check("rst_wen", {31'b0, mem_wen}, 32'h0);
        check("rst_rvalid", {30'b0, rvalid1, rvalid0}, 32'h0);
        step();
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            expect_grant(tie_seq[i], tie_seq[i] ? 32'h300 : 32'h100, 32'h0, 1'b0,
                         tie_seq[i] ? 3'b100 : 3'b010, 1'b1);
            step();
        end
        set_idle();
        step();

        req0 = 1'b1;
        addr0 = 32'h10;
        funct3_0 = 3'b010;
        expect_grant(1'b0, 32'h10, 32'h0, 1'b0, 3'b010, 1'b1);
        step();
        set_idle();
        step();

        req1 = 1'b1;
        we1 = 1'b1;
        addr1 = 32'h200;
        wd1 = 32'h12345678;
        funct3_1 = 3'b001;
        expect_grant(1'b1, 32'h200, 32'h12345678, 1'b1, 3'b001, 1'b0);
        step();
        set_idle();
        check("write_no_rvalid1", {31'b0, rvalid1}, 32'h0);
        step();

        req0 = 1'b1;
        addr0 = 32'h20;
        wd0 = 32'h0;
        for (int i = 0; i < 6; i++) begin
            expect_grant(1'b0, 32'h20, 32'h0, 1'b0, 3'b010, 1'b1);
            step();
        end
        req1 = 1'b1;
        addr1 = 32'h300;
        wd1 = 32'h0;
        funct3_1 = 3'b100;
        for (int i = 0; i < 2; i++) begin
            expect_grant(tail_seq[i], tail_seq[i] ? 32'h300 : 32'h20, 32'h0, 1'b0,
                         tail_seq[i] ? 3'b100 : 3'b010, 1'b1);
            step();
        end
        set_idle();
        step();
        step();

        req0 = 1'b1;
        addr0 = 32'h40;
        expect_grant(1'b0, 32'h40, 32'h0, 1'b0, 3'b010, 1'b0);
        step();
        check("pre_rst_rvalid0", {31'b0, rvalid0}, 32'h1);
        check("pre_rst_rd0", rd0, memval(32'h40));
        rst_n = 1'b0;
        we0 = 1'b1;
        #1;
        check("mid_rst_rvalid0", {31'b0, rvalid0}, 32'h0);
        check("mid_rst_gnt", {30'b0, gnt1, gnt0}, 32'h0);
        check("mid_rst_wen", {31'b0, mem_wen}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("hold_rst_gnt", {30'b0, gnt1, gnt0}, 32'h0);
            check("hold_rst_rvalid", {30'b0, rvalid1, rvalid0}, 32'h0);
        end
        rst_n = 1'b1;
        set_idle();
        step();
        step();

        check("grant_queue_drained", gq.size(), 32'h0);
        check("read_queue_drained", rq.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single synchronous-read memory port between two requesters: port 0 (CPU core) and port 1 (loader/DMA engine). Each cycle it grants at most one request, drives the shared memory address/data/write-enable/funct3 lines, and returns read data to the granted port one cycle later. It sits between the requesters and the unified instruction/data memory and replaces the direct core-to-memory connection.

## Interface
Parameters:
- `MAX_BURST`, default 4: consecutive grants one port may hold while the other port is requesting; minimum 1.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  input  1  system clock; all state updates on the rising edge.
  - `rst_n`  input  1  asynchronous active-low reset.
- `req0`, `req1`  input  1  request valid, held until granted.
- `we0`, `we1`  input  1  1 = write, 0 = read.
- `addr0`, `addr1`  input  32  byte address.
- `wd0`, `wd1`  input  32  write data.
- `funct3_0`, `funct3_1`  input  3  access size/sign code, passed to memory unchanged.
- `gnt0`, `gnt1`  output  1  combinational grant, valid in the request cycle.
- `rvalid0`, `rvalid1`  output  1  read data valid for the port, one cycle after a granted read.
- `rd0`, `rd1`  output  32  read data; `mem_rd` when the port's `rvalid` is high, else 0.
- `mem_wen`  output  1  memory write enable.
- `mem_ra`  output  32  memory read address.
- `mem_wa`  output  32  memory write address.
- `mem_wd`  output  32  memory write data.
- `mem_funct3`  output  3  memory function code.
- `mem_rd`  input  32  memory read data; valid the cycle after `mem_ra`.

## Operation
- Grant rule:
  - One requester: it is granted.
  - Both requesting: the port that did not hold the last grant wins (round-robin), except for burst continuation.
  - Burst continuation: if the last owner is still requesting and `burst_cnt < MAX_BURST`, it keeps the grant.
- Never both grants in one cycle. No request: no grant, and `mem_wen = 0`.
- Granted port drives both `mem_ra` and `mem_wa` from its `addr`, plus `mem_wd`, `mem_funct3` and `mem_wen = weX`.
- Idle cycle: `mem_ra = 0`, `mem_wa = 0`, `mem_wd = 0`, `mem_funct3 = 3'b010`.
- Registered state:
  - `last_owner`, 1 bit.
  - `burst_cnt`, width `$clog2(MAX_BURST+1)`, saturating at `MAX_BURST`.
  - `rvalid` pipeline, 2 bits: one `rvalid` bit per port.
- `burst_cnt` update: resets to 1 when the grant changes owner; increments when the same owner is granted again; clears to 0 on an idle cycle.
- Idle cycles do not change `last_owner`.
- Granted write: committed at the next rising edge; no `rvalid`.
- Granted read: the port's `rvalid` is high the next cycle.

## Timing
- Request-to-grant latency: 0 cycles (combinational).
- Read data latency: 1 cycle.
- Back-to-back grants are allowed every cycle, so throughput is 1 access/cycle.
- A denied requester must hold `req`, `we`, `addr`, `wd` and `funct3` stable until granted.
- Reset values (`rst_n` low):
  - `last_owner = 1`, so port 0 wins the first tie.
  - `burst_cnt = 0`.
  - `rvalid0 = rvalid1 = 0`.
  - `gnt0 = gnt1 = 0` and `mem_wen = 0` are forced while reset is asserted.
- Reset asserted mid-read: the pending `rvalid` is dropped and not replayed.
- Boundary: with `MAX_BURST = 1` the arbiter alternates strictly whenever both ports request.
- Boundary: a port requesting alone never sees its burst limit enforced.

## Configuration
- Macro: `MEM_ARB_FIXED_PRIO_EN`.
- Defined: port 0 always wins when both ports request. `burst_cnt` and `MAX_BURST` are ignored; `last_owner` is still tracked.
- Undefined: round-robin with burst limit, as described under Operation.

## Structure
- Add to the shared `types` package:
  - `arb_port_t` (enum `PORT_CPU = 0`, `PORT_AUX = 1`).
  - `FUNCT3_WORD = 3'b010`, the idle/fetch code.
- Sub-module `arb_grant`: combinational grant decision from `req0`, `req1`, `last_owner`, `burst_cnt` and `MAX_BURST`.
- The top level holds the registers and the memory-port muxing.

## Test plan
- Reset, then `req0` alone reading `addr0 = 0x10`, memory returns `0xDEADBEEF` → `gnt0 = 1` and `mem_ra = 0x10` in the cycle; next cycle `rvalid0 = 1`, `rd0 = 0xDEADBEEF`, `rvalid1 = 0`.
- First cycle after reset, both ports request → `gnt0 = 1`, `gnt1 = 0`.
- Both ports hold requests for 10 cycles with `MAX_BURST = 4` → grant sequence 0,0,0,0,1,1,1,1,0,0.
- Port 1 writes `0x12345678` to `0x200` alone → `mem_wen = 1`, `mem_wa = 0x200`, `mem_wd = 0x12345678`, `mem_funct3 = funct3_1`; no `rvalid1` the next cycle.
- Assert `rst_n` low in the cycle after a granted read → `rvalid0` goes low immediately; grants stay 0 until release.
- With `MEM_ARB_FIXED_PRIO_EN` defined, both ports request for 6 cycles → `gnt0 = 1` in every cycle, `gnt1` never asserted.
